// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: steps the nlp-16a ALU through one operation per request.
// Multi-bit shifts/rotates become repeated 1-bit ALU steps. Every step holds
// the ALU control word for SETTLE cycles. Outputs are decoded from registered
// state, latched opcode and counters. Flush is the only input that reaches
// the outputs combinationally: it gates the write strobes.
module alu_op_sequencer #(
  parameter int SHAMT_W = 4,
  parameter int SETTLE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         op_code,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic [5:0]         alu_ctrl,
  output logic               acc_sel,
  output logic               acc_we,
  output logic               wb_en,
  output logic               flag_we,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int STEP_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [5:0] CTRL_MOV = 6'b000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_WB,
    S_ERR
  } state_t;

  state_t             state, state_next;
  logic [3:0]         op_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [SHAMT_W-1:0] shift_cnt, shift_cnt_next;
  logic [STEP_W-1:0]  step_cnt, step_cnt_next;
  logic               accept;
  logic               is_shift;
  logic               zero_shift;
  logic               step_last;
  logic [5:0]         op_ctrl;

  // The control words are listed as Ctrl0..Ctrl5 reading left to right.
  // alu_ctrl[i] carries Ctrl i, so the listed pattern is bit-reversed.
  function automatic logic [5:0] ctrl_code(input logic [3:0] op);
    logic [5:0] t;
    case (op)
      4'd1:    t = 6'b010010;
      4'd2:    t = 6'b010001;
      4'd3:    t = 6'b000110;
      4'd4:    t = 6'b001010;
      4'd5:    t = 6'b001110;
      4'd6:    t = 6'b001100;
      4'd7:    t = 6'b011011;
      4'd8:    t = 6'b011000;
      4'd9:    t = 6'b100100;
      4'd10:   t = 6'b100000;
      4'd11:   t = 6'b100010;
      4'd12:   t = 6'b101100;
      4'd13:   t = 6'b101000;
      4'd14:   t = 6'b101010;
      default: t = 6'b000000;
    endcase
    return {t[0], t[1], t[2], t[3], t[4], t[5]};
  endfunction

  assign accept     = (state == S_IDLE) && req_valid;
  assign is_shift   = (op_q >= 4'd9) && (op_q <= 4'd14);
  assign zero_shift = is_shift && (shamt_q == '0);
  assign step_last  = (step_cnt == STEP_W'(SETTLE - 1));
  assign op_ctrl    = ctrl_code(op_q);

  // State register, latched request and step/shift counters.
  // shift_cnt holds the number of 1-bit steps still owed, including the WB step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      shamt_q   <= '0;
      shift_cnt <= '0;
      step_cnt  <= '0;
    end else begin
      state     <= state_next;
      shift_cnt <= shift_cnt_next;
      step_cnt  <= step_cnt_next;
      if (accept) begin
        op_q      <= op_code;
        shamt_q   <= shamt;
        shift_cnt <= shamt;
      end
    end
  end

  // Next-state, counter updates and output decode. Flush overrides step completion.
  always_comb begin
    state_next     = state;
    shift_cnt_next = shift_cnt;
    step_cnt_next  = step_cnt;
    req_ready      = 1'b0;
    alu_ctrl       = CTRL_MOV;
    acc_sel        = 1'b0;
    acc_we         = 1'b0;
    wb_en          = 1'b0;
    flag_we        = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    busy           = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = (op_code == 4'd15) ? S_ERR : S_LOAD;
        end
      end
      S_LOAD: begin
        acc_we        = 1'b1;
        step_cnt_next = '0;
        state_next    = (is_shift && (shift_cnt > SHAMT_W'(1))) ? S_EXEC : S_WB;
      end
      S_EXEC: begin
        alu_ctrl = op_ctrl;
        acc_sel  = 1'b1;
        if (step_last) begin
          acc_we         = 1'b1;
          step_cnt_next  = '0;
          shift_cnt_next = shift_cnt - SHAMT_W'(1);
          state_next     = (shift_cnt == SHAMT_W'(2)) ? S_WB : S_EXEC;
        end else begin
          step_cnt_next = step_cnt + STEP_W'(1);
        end
      end
      S_WB: begin
        alu_ctrl = zero_shift ? CTRL_MOV : op_ctrl;
        if (step_last) begin
          wb_en         = 1'b1;
          done          = 1'b1;
          flag_we       = !((op_q == 4'd0) || zero_shift);
          step_cnt_next = '0;
          state_next    = S_IDLE;
        end else begin
          step_cnt_next = step_cnt + STEP_W'(1);
        end
      end
      S_ERR: begin
        done       = 1'b1;
        err        = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (flush && (state != S_IDLE)) begin
      acc_we        = 1'b0;
      wb_en         = 1'b0;
      flag_we       = 1'b0;
      done          = 1'b0;
      err           = 1'b0;
      step_cnt_next = '0;
      state_next    = S_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: drives two sequencers (SETTLE=1 and SETTLE=3). It
// compares every cycle of each operation against expected output sequences
// built from the operation rules, and checks accept-to-done latencies.
module tb_alu_op_sequencer;

  typedef logic [13:0] vec_q_t [$];

  typedef struct {
    int dut;
    int op;
    int shamt;
    int flush_idx;
    int exp_lat;
  } vec_t;

  localparam logic [13:0] STROBE_MASK = 14'h0076;

  logic       clk = 1'b0;
  logic       rst;
  logic       rv      [2];
  logic       ready   [2];
  logic [3:0] opc     [2];
  logic [3:0] sh      [2];
  logic       fl      [2];
  logic [5:0] ctrl    [2];
  logic       acc_sel [2];
  logic       acc_we  [2];
  logic       wb_en   [2];
  logic       flag_we [2];
  logic       busy    [2];
  logic       done    [2];
  logic       err     [2];

  int checks   = 0;
  int failures = 0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  alu_op_sequencer #(.SHAMT_W(4), .SETTLE(1)) dut_s1 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(ready[0]),
    .op_code(opc[0]), .shamt(sh[0]), .flush(fl[0]), .alu_ctrl(ctrl[0]),
    .acc_sel(acc_sel[0]), .acc_we(acc_we[0]), .wb_en(wb_en[0]),
    .flag_we(flag_we[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  alu_op_sequencer #(.SHAMT_W(4), .SETTLE(3)) dut_s3 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(ready[1]),
    .op_code(opc[1]), .shamt(sh[1]), .flush(fl[1]), .alu_ctrl(ctrl[1]),
    .acc_sel(acc_sel[1]), .acc_we(acc_we[1]), .wb_en(wb_en[1]),
    .flag_we(flag_we[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  function automatic logic [13:0] mk_vec(input logic [5:0] c, input bit sel, input bit we,
                                         input bit wb, input bit fw, input bit bz,
                                         input bit dn, input bit er, input bit rd);
    return {c, sel, we, wb, fw, bz, dn, er, rd};
  endfunction

  function automatic logic [13:0] get_out(input int d);
    return {ctrl[d], acc_sel[d], acc_we[d], wb_en[d], flag_we[d], busy[d], done[d], err[d], ready[d]};
  endfunction

  // Control words as written in the operation table, Ctrl0 first.
  function automatic logic [5:0] code_text(input int op);
    case (op)
      1:       return 6'b010010;
      2:       return 6'b010001;
      3:       return 6'b000110;
      4:       return 6'b001010;
      5:       return 6'b001110;
      6:       return 6'b001100;
      7:       return 6'b011011;
      8:       return 6'b011000;
      9:       return 6'b100100;
      10:      return 6'b100000;
      11:      return 6'b100010;
      12:      return 6'b101100;
      13:      return 6'b101000;
      14:      return 6'b101010;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] to_ctrl(input int op);
    logic [5:0] t;
    logic [5:0] r;
    t = code_text(op);
    for (int i = 0; i < 6; i++) r[i] = t[5 - i];
    return r;
  endfunction

  // Expected per-cycle outputs from the cycle after accept through the done cycle.
  function automatic vec_q_t build_expected(input int op, input int shamt, input int settle);
    vec_q_t q;
    bit is_shift;
    bit zero;
    logic [5:0] wb_ctrl;
    is_shift = (op >= 9) && (op <= 14);
    zero     = is_shift && (shamt == 0);
    if (op == 15) begin
      q.push_back(mk_vec(6'b0, 0, 0, 0, 0, 1, 1, 1, 0));
      return q;
    end
    q.push_back(mk_vec(6'b0, 0, 1, 0, 0, 1, 0, 0, 0));
    if (is_shift && shamt >= 1) begin
      for (int s = 0; s < shamt - 1; s++)
        for (int c = 0; c < settle; c++)
          q.push_back(mk_vec(to_ctrl(op), 1, (c == settle - 1), 0, 0, 1, 0, 0, 0));
    end
    wb_ctrl = zero ? 6'b0 : to_ctrl(op);
    for (int c = 0; c < settle; c++) begin
      bit last;
      last = (c == settle - 1);
      q.push_back(mk_vec(wb_ctrl, 0, 0, last, last && !((op == 0) || zero), 1, last, 0, 0));
    end
    return q;
  endfunction

  function automatic int exp_latency(input int op, input int shamt, input int settle);
    if (op == 15) return 1;
    if ((op >= 9) && (op <= 14) && (shamt >= 1)) return 1 + shamt * settle;
    return 1 + settle;
  endfunction

  task automatic checkOutput(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b required=%b (ctrl,sel,acc_we,wb,flag,busy,done,err,ready)",
               name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Runs one operation on DUT d starting from an idle cycle just after a negedge.
  task automatic applyStimulus(input int d, input int op, input int shamt,
                               input int flush_idx, input int exp_lat, input string name);
    vec_q_t e;
    logic [13:0] idle_v;
    logic [13:0] ev;
    int done_at;
    e       = build_expected(op, shamt, (d == 0) ? 1 : 3);
    idle_v  = mk_vec(6'b0, 0, 0, 0, 0, 0, 0, 0, 1);
    done_at = -1;
    checkOutput({name, "/idle_before"}, get_out(d), idle_v);
    rv[d]  = 1'b1;
    opc[d] = 4'(op);
    sh[d]  = 4'(shamt);
    for (int j = 0; j < e.size(); j++) begin
      @(posedge clk);
      #1;
      rv[d]  = 1'($urandom_range(0, 1));
      opc[d] = 4'($urandom);
      sh[d]  = 4'($urandom);
      fl[d]  = (j == flush_idx);
      @(negedge clk);
      ev = e[j];
      if (j == flush_idx) ev = ev & ~STROBE_MASK;
      checkOutput($sformatf("%s/cyc%0d", name, j), get_out(d), ev);
      if (done[d]) done_at = j + 1;
      if (j == flush_idx) break;
    end
    @(posedge clk);
    #1;
    rv[d] = 1'b0;
    fl[d] = 1'b0;
    @(negedge clk);
    checkOutput({name, "/idle_after"}, get_out(d), idle_v);
    checkInt({name, "/latency"}, done_at, exp_lat);
  endtask

  // Main sequence: reset, table vectors, reset-in-flight sequence, random ops.
  initial begin
    vec_t tbl [12];
    logic [13:0] rst_v;
    rst_v = mk_vec(6'b0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; opc[d] = 4'd0; sh[d] = 4'd0; fl[d] = 1'b0;
    end
    tbl[0]  = '{0, 1, 0, -1, 2};
    tbl[1]  = '{0, 10, 3, -1, 4};
    tbl[2]  = '{0, 14, 0, -1, 2};
    tbl[3]  = '{0, 15, 5, -1, 1};
    tbl[4]  = '{1, 2, 0, -1, 4};
    tbl[5]  = '{0, 0, 7, -1, 2};
    tbl[6]  = '{0, 12, 15, 5, -1};
    tbl[7]  = '{1, 11, 2, -1, 7};
    tbl[8]  = '{0, 15, 0, 0, -1};
    tbl[9]  = '{1, 7, 0, 3, -1};
    tbl[10] = '{1, 13, 1, -1, 4};
    tbl[11] = '{0, 9, 1, -1, 2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset/s1", get_out(0), rst_v);
    checkOutput("reset/s3", get_out(1), rst_v);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      applyStimulus(tbl[i].dut, tbl[i].op, tbl[i].shamt, tbl[i].flush_idx, tbl[i].exp_lat,
                    $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of an SRA, with a new request waiting.
    rv[0] = 1'b1; opc[0] = 4'd12; sh[0] = 4'd15;
    @(posedge clk);
    #1;
    opc[0] = 4'd1; sh[0] = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_seq/exec", get_out(0), mk_vec(to_ctrl(12), 1, 1, 0, 0, 1, 0, 0, 0));
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_seq/async", get_out(0), rst_v);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_seq/held_idle", get_out(0), rst_v);
    @(posedge clk);
    #1 rv[0] = 1'b0;
    @(negedge clk);
    checkOutput("rst_seq/load", get_out(0), mk_vec(6'b0, 0, 1, 0, 0, 1, 0, 0, 0));
    @(negedge clk);
    checkOutput("rst_seq/wb", get_out(0), mk_vec(to_ctrl(1), 0, 0, 1, 1, 1, 1, 0, 0));
    @(negedge clk);
    checkOutput("rst_seq/idle", get_out(0), rst_v);

    for (int i = 0; i < 40; i++) begin
      int d, op, shamt, lat, fidx;
      d     = $urandom_range(0, 1);
      op    = $urandom_range(0, 15);
      shamt = $urandom_range(0, 15);
      lat   = exp_latency(op, shamt, (d == 0) ? 1 : 3);
      fidx  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat - 1) : -1;
      applyStimulus(d, op, shamt, fidx, (fidx >= 0) ? -1 : lat, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
